if_fetch_unit: RTL and testbench
================================

// Module: if_fetch_unit
// PURPOSE
//  Instruction-fetch stage feeding the IF/ID pipeline register. Holds the fetch PC and runs a single-outstanding
//  req/ack transaction to instruction memory (variable wait states). Buffers returned words in a 2-entry FIFO and
//  presents {PC+4, instruction} to the IF/ID register. Branch redirects flush the FIFO and squash any in-flight
//  fetch. When no instruction is available, the output is a NOP.
// PARAMETERS
//  RESET_PC  32'h0000_0000  fetch address after reset (word aligned)
//  NOP_INSTR 32'hE000_0000  word driven on instr_out when no valid instruction
// PORTS
//  clk           in   1   clock, all state on rising edge
//  rst           in   1   asynchronous, active-high reset
//  freeze        in   1   hazard stall; IF/ID register does not capture this edge
//  branch_taken  in   1   redirect request from EXE
//  branch_addr   in   32  redirect target; bits[1:0] ignored (forced 0)
//  imem_req      out  1   memory request, registered
//  imem_addr     out  32  request address, registered, stable while imem_req=1
//  imem_ack      in   1   1-cycle pulse, data valid; legal in any cycle imem_req=1, incl. first
//  imem_rdata    in   32  instruction word, sampled only when imem_ack=1
//  pc_out        out  32  address+4 of instr_out (FIFO head), 0 when empty
//  instr_out     out  32  FIFO head, NOP_INSTR when empty
//  instr_valid   out  1   FIFO non-empty
// BEHAVIOUR
//  Reset (async): state=IDLE; pc=RESET_PC; FIFO empty; imem_req=0; imem_addr=RESET_PC; pc_out=0;
//   instr_out=NOP_INSTR; instr_valid=0. Reset mid-transaction abandons it; any later ack is ignored (IDLE).
//  pop = instr_valid & !freeze & !branch_taken. The consumer captures on that edge; nothing else acknowledges.
//  cnt = FIFO occupancy (0..2); cnt_n = cnt + push - pop. push writes {imem_rdata, pc+4} at the tail.
//  States. imem_req=1 in BUSY and DROP, 0 in IDLE. On every entry to BUSY: imem_addr <= pc_next.
//   IDLE: branch_taken -> flush, pc<=branch_addr, BUSY.
//         else if (cnt - pop) < 2 -> BUSY.
//   BUSY: branch_taken & imem_ack -> data discarded, flush, pc<=branch_addr, BUSY (new addr next cycle).
//         branch_taken & !imem_ack -> flush, pc<=branch_addr, DROP (imem_addr held).
//         imem_ack -> push, pc<=pc+4; BUSY (new addr) if cnt_n<2, else IDLE.
//         no ack -> hold.
//   DROP: imem_ack -> discard, BUSY with imem_addr<=pc.
//         branch_taken -> pc<=branch_addr (FIFO already empty), stay DROP.
//  Priority: rst > branch_taken > freeze. A flush empties the FIFO at that edge (instr_valid=0 next cycle)
//   even if freeze=1.
//  Push and pop in the same edge are allowed at any cnt.
//  Push with cnt=2 cannot occur; a request is issued only with space.
//  Arithmetic: pc+4 mod 2^32 (0xFFFF_FFFC -> 0x0000_0000); pc always word aligned.
//  Latency: zero-wait memory, no stalls -> first instr_valid 2 cycles after reset release, then 1 instr/cycle.
//   N wait states -> 1 instr per N+1 cycles.
//  No combinational path from any input to any output.
// TESTING
//  1 Zero-wait mem, mem[a]=a^32'hA5A5_0000, RESET_PC=0 -> instr_valid from cycle 2;
//    instr_out mem[0],mem[4],mem[8] on consecutive cycles; pc_out 4,8,C.
//  2 As 1, freeze=1 for 4 cycles -> cnt reaches 2, imem_req drops, head held.
//    After release, sequence continues with no loss or duplication.
//  3 Memory with 3 wait states, branch_taken with branch_addr=0x100 while BUSY at 0x8 -> DROP;
//    imem_addr stays 0x8 until ack; that word is never output; next imem_addr=0x100;
//    next valid instr_out=mem[0x100], pc_out=0x104.
//  4 branch_taken (0x200) in same cycle as imem_ack -> acked word dropped;
//    next cycle imem_req=1, imem_addr=0x200.
//  5 branch_taken while freeze=1, cnt=2 -> next cycle instr_valid=0, instr_out=NOP_INSTR,
//    fetch resumes at branch_addr.
//  6 RESET_PC=0xFFFF_FFF8, zero-wait -> pc_out 0xFFFF_FFFC, 0x0, 0x4 (wrap).
//    Then assert rst while waiting on ack -> all outputs at reset values immediately, stale ack ignored.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: single-outstanding req/ack fetch into a 2-entry FIFO feeding IF/ID.
// Branch redirects flush the FIFO; an in-flight fetch is drained in DROP and its data discarded.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'hE000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] instr_out,
  output logic        instr_valid
);

  typedef enum logic [1:0] {IDLE, BUSY, DROP} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [1:0]  cnt;
  logic [31:0] head_instr, head_pc, tail_instr, tail_pc;

  logic        pop, push;
  logic [1:0]  wr_idx, cnt_n;
  logic [31:0] br_target, pc_inc;

  assign instr_valid = (cnt != 2'd0);
  assign pop         = instr_valid & ~freeze & ~branch_taken;
  assign push        = (state == BUSY) & imem_ack & ~branch_taken;
  assign wr_idx      = cnt - 2'(pop);
  assign cnt_n       = wr_idx + 2'(push);
  assign br_target   = branch_addr & 32'hFFFF_FFFC;
  assign pc_inc      = pc + 32'd4;

  assign pc_out    = instr_valid ? head_pc : 32'd0;
  assign instr_out = instr_valid ? head_instr : NOP_INSTR;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      imem_req   <= 1'b0;
      imem_addr  <= RESET_PC;
      cnt        <= 2'd0;
      head_instr <= NOP_INSTR;
      head_pc    <= 32'd0;
      tail_instr <= NOP_INSTR;
      tail_pc    <= 32'd0;
    end else begin
      // A redirect empties the FIFO even when the consumer is frozen.
      if (branch_taken) begin
        cnt <= 2'd0;
      end else begin
        cnt <= cnt_n;
        if (pop) begin
          head_instr <= tail_instr;
          head_pc    <= tail_pc;
        end
        if (push) begin
          if (wr_idx == 2'd0) begin
            head_instr <= imem_rdata;
            head_pc    <= pc_inc;
          end else begin
            tail_instr <= imem_rdata;
            tail_pc    <= pc_inc;
          end
        end
      end

      unique case (state)
        IDLE: begin
          if (branch_taken) begin
            pc        <= br_target;
            imem_addr <= br_target;
            imem_req  <= 1'b1;
            state     <= BUSY;
          end else if (wr_idx < 2'd2) begin
            imem_addr <= pc;
            imem_req  <= 1'b1;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (branch_taken) begin
            pc <= br_target;
            if (imem_ack) begin
              imem_addr <= br_target;
              state     <= BUSY;
            end else begin
              state <= DROP;
            end
          end else if (imem_ack) begin
            pc <= pc_inc;
            if (cnt_n < 2'd2) begin
              imem_addr <= pc_inc;
            end else begin
              imem_req <= 1'b0;
              state    <= IDLE;
            end
          end
        end
        DROP: begin
          // Wait out the squashed fetch, then restart at the latest redirect target.
          if (branch_taken) pc <= br_target;
          if (imem_ack) begin
            imem_addr <= branch_taken ? br_target : pc;
            state     <= BUSY;
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios plus randomized freeze/branch/wait-state traffic,
// checked against a program-order stream model of what the consumer must see.
module tb_if_fetch_unit;
  localparam logic [31:0] NOP = 32'hE000_0000;

  logic        clk = 1'b0, rst = 1'b1, rst2 = 1'b1;
  logic        freeze = 1'b0, branch_taken = 1'b0, stale_ack = 1'b0;
  logic [31:0] branch_addr = 32'd0;
  logic        imem_req, imem_ack, instr_valid;
  logic [31:0] imem_addr, imem_rdata, pc_out, instr_out;
  logic        imem_req2, instr_valid2;
  logic [31:0] imem_addr2, pc_out2, instr_out2;

  int checks = 0, errors = 0, pops = 0;
  int wait_n = 0, wcnt;
  logic [31:0] exp_pc = 32'd0, prev_addr = 32'd0;
  logic        flushed = 1'b0, prev_req = 1'b0, prev_ack = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // Memory with wait_n wait states; stale_ack injects an unsolicited ack with junk data.
  assign imem_ack   = (imem_req && wcnt >= wait_n) || stale_ack;
  assign imem_rdata = stale_ack ? 32'hDEAD_BEEF : memf(imem_addr);
  always @(posedge clk or posedge rst)
    if (rst) wcnt <= 0;
    else if (imem_req && !imem_ack) wcnt <= wcnt + 1;
    else wcnt <= 0;

  if_fetch_unit dut (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken), .branch_addr(branch_addr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .pc_out(pc_out), .instr_out(instr_out), .instr_valid(instr_valid)
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .rst(rst2), .freeze(1'b0), .branch_taken(1'b0), .branch_addr(32'd0),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ack(imem_req2), .imem_rdata(memf(imem_addr2)),
    .pc_out(pc_out2), .instr_out(instr_out2), .instr_valid(instr_valid2)
  );

  // Stream model: consumer must see consecutive words from the last redirect target.
  always @(negedge clk) begin
    if (rst) begin
      exp_pc = 32'd0; flushed = 1'b0; prev_req = 1'b0; prev_ack = 1'b0;
    end else begin
      if (flushed) begin
        checks++;
        if (instr_valid !== 1'b0) begin
          errors++; $display("FAIL flush_empty valid=%0b expected 0", instr_valid);
        end
      end
      checks++;
      if (instr_valid) begin
        if (instr_out !== memf(exp_pc) || pc_out !== exp_pc + 32'd4) begin
          errors++;
          $display("FAIL stream instr=%h pc_out=%h expected %h %h", instr_out, pc_out, memf(exp_pc), exp_pc + 32'd4);
        end
      end else if (instr_out !== NOP || pc_out !== 32'd0) begin
        errors++; $display("FAIL empty_out instr=%h pc_out=%h expected %h 0", instr_out, pc_out, NOP);
      end
      if (instr_valid && !freeze && !branch_taken) begin
        exp_pc = exp_pc + 32'd4; pops++;
      end
      if (branch_taken) begin
        exp_pc = branch_addr & 32'hFFFF_FFFC; flushed = 1'b1;
      end else flushed = 1'b0;
      if (prev_req && imem_req && !prev_ack) begin
        checks++;
        if (imem_addr !== prev_addr) begin
          errors++; $display("FAIL addr_stable addr=%h expected %h", imem_addr, prev_addr);
        end
      end
      prev_req = imem_req; prev_addr = imem_addr; prev_ack = imem_ack;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; rst2 = 1'b1;
    repeat (2) tick();
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== 32'd0 || instr_valid !== 1'b0 || instr_out !== NOP || pc_out !== 32'd0) begin
      errors++;
      $display("FAIL reset_state req=%0b addr=%h valid=%0b instr=%h pc=%h expected 0 0 0 %h 0",
               imem_req, imem_addr, instr_valid, instr_out, pc_out, NOP);
    end
    checks++;
    if (imem_req2 !== 1'b0 || imem_addr2 !== 32'hFFFF_FFF8 || instr_valid2 !== 1'b0 || pc_out2 !== 32'd0) begin
      errors++;
      $display("FAIL reset_state2 req=%0b addr=%h valid=%0b pc=%h expected 0 fffffff8 0 0",
               imem_req2, imem_addr2, instr_valid2, pc_out2);
    end
  endtask

  task automatic test_zero_wait();
    wait_n = 0; rst = 1'b0;
    tick();
    checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'd0) begin
      errors++; $display("FAIL first_req valid=%0b req=%0b addr=%h expected 0 1 0", instr_valid, imem_req, imem_addr);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (instr_valid !== 1'b1 || instr_out !== memf(32'(4 * k)) || pc_out !== 32'(4 * k + 4)) begin
        errors++;
        $display("FAIL zero_wait_seq k=%0d valid=%0b instr=%h pc=%h expected 1 %h %h",
                 k, instr_valid, instr_out, pc_out, memf(32'(4 * k)), 32'(4 * k + 4));
      end
    end
  endtask

  task automatic test_freeze();
    freeze = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (instr_valid !== 1'b1 || pc_out !== 32'hC || instr_out !== memf(32'h8)) begin
        errors++; $display("FAIL freeze_hold pc=%h instr=%h expected c %h", pc_out, instr_out, memf(32'h8));
      end
    end
    checks++;
    if (imem_req !== 1'b0) begin
      errors++; $display("FAIL freeze_req req=%0b expected 0", imem_req);
    end
    freeze = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (instr_valid !== 1'b1 || pc_out !== 32'(16 + 4 * k)) begin
        errors++; $display("FAIL freeze_resume valid=%0b pc=%h expected 1 %h", instr_valid, pc_out, 32'(16 + 4 * k));
      end
    end
  endtask

  task automatic test_drop();
    bit found = 0;
    rst = 1'b1; wait_n = 3;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      tick();
      if (imem_req && imem_addr == 32'h8) found = 1;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL drop_reach_8 addr=%h expected 8", imem_addr);
    end
    branch_taken = 1'b1; branch_addr = 32'h100;
    tick();
    branch_taken = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h8 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL drop_hold req=%0b addr=%h valid=%0b expected 1 8 0", imem_req, imem_addr, instr_valid);
    end
    for (int k = 0; k < 20 && imem_addr == 32'h8; k++) tick();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      errors++; $display("FAIL drop_redirect req=%0b addr=%h expected 1 100", imem_req, imem_addr);
    end
    for (int k = 0; k < 20 && !instr_valid; k++) tick();
    checks++;
    if (instr_valid !== 1'b1 || instr_out !== memf(32'h100) || pc_out !== 32'h104) begin
      errors++; $display("FAIL drop_first valid=%0b instr=%h pc=%h expected 1 %h 104", instr_valid, instr_out, pc_out, memf(32'h100));
    end
  endtask

  task automatic test_branch_ack();
    wait_n = 0;
    repeat (3) tick();
    branch_taken = 1'b1; branch_addr = 32'h200;
    tick();
    branch_taken = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h200 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL branch_ack req=%0b addr=%h valid=%0b expected 1 200 0", imem_req, imem_addr, instr_valid);
    end
    tick();
    checks++;
    if (instr_valid !== 1'b1 || instr_out !== memf(32'h200) || pc_out !== 32'h204) begin
      errors++; $display("FAIL branch_ack_first instr=%h pc=%h expected %h 204", instr_out, pc_out, memf(32'h200));
    end
  endtask

  task automatic test_branch_freeze();
    freeze = 1'b1;
    repeat (3) tick();
    checks++;
    if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin
      errors++; $display("FAIL full_idle valid=%0b req=%0b expected 1 0", instr_valid, imem_req);
    end
    branch_taken = 1'b1; branch_addr = 32'h300;
    tick();
    branch_taken = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || instr_out !== NOP || pc_out !== 32'd0 || imem_req !== 1'b1 || imem_addr !== 32'h300) begin
      errors++;
      $display("FAIL branch_freeze valid=%0b instr=%h pc=%h req=%0b addr=%h expected 0 %h 0 1 300",
               instr_valid, instr_out, pc_out, imem_req, imem_addr, NOP);
    end
    freeze = 1'b0;
    tick();
    checks++;
    if (instr_valid !== 1'b1 || instr_out !== memf(32'h300) || pc_out !== 32'h304) begin
      errors++; $display("FAIL branch_freeze_first instr=%h pc=%h expected %h 304", instr_out, pc_out, memf(32'h300));
    end
  endtask

  task automatic test_wrap();
    logic [31:0] addrs [3];
    addrs[0] = 32'hFFFF_FFF8; addrs[1] = 32'hFFFF_FFFC; addrs[2] = 32'h0000_0000;
    rst2 = 1'b0;
    tick();
    checks++;
    if (instr_valid2 !== 1'b0 || imem_req2 !== 1'b1 || imem_addr2 !== 32'hFFFF_FFF8) begin
      errors++; $display("FAIL wrap_first_req valid=%0b req=%0b addr=%h expected 0 1 fffffff8", instr_valid2, imem_req2, imem_addr2);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (instr_valid2 !== 1'b1 || instr_out2 !== memf(addrs[k]) || pc_out2 !== addrs[k] + 32'd4) begin
        errors++;
        $display("FAIL wrap_seq k=%0d instr=%h pc=%h expected %h %h", k, instr_out2, pc_out2, memf(addrs[k]), addrs[k] + 32'd4);
      end
    end
  endtask

  task automatic test_reset_mid();
    wait_n = 5; freeze = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 40 && !(instr_valid && imem_req); k++) tick();
    tick();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== 32'd0 || instr_valid !== 1'b0 || instr_out !== NOP || pc_out !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid req=%0b addr=%h valid=%0b instr=%h pc=%h expected 0 0 0 %h 0",
               imem_req, imem_addr, instr_valid, instr_out, pc_out, NOP);
    end
    stale_ack = 1'b1;
    tick();
    rst = 1'b0; freeze = 1'b0;
    tick();
    stale_ack = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'd0) begin
      errors++; $display("FAIL stale_ack valid=%0b req=%0b addr=%h expected 0 1 0", instr_valid, imem_req, imem_addr);
    end
    for (int k = 0; k < 20 && !instr_valid; k++) tick();
    checks++;
    if (instr_valid !== 1'b1 || instr_out !== memf(32'd0) || pc_out !== 32'd4) begin
      errors++; $display("FAIL restart_first instr=%h pc=%h expected %h 4", instr_out, pc_out, memf(32'd0));
    end
  endtask

  task automatic test_random();
    int p0 = pops;
    for (int i = 0; i < 800; i++) begin
      if (i % 100 == 0) wait_n = int'($urandom_range(0, 3));
      freeze       = ($urandom_range(0, 9) < 3);
      branch_taken = ($urandom_range(0, 24) == 0);
      branch_addr  = $urandom;
      tick();
    end
    freeze = 1'b0; branch_taken = 1'b0;
    tick();
    checks++;
    if (pops - p0 < 100) begin
      errors++; $display("FAIL random_progress pops=%0d expected at least 100", pops - p0);
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_freeze();
    test_drop();
    test_branch_ack();
    test_branch_freeze();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
